// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares one stream UART's byte input between N_REQ requesters.
// Latency: one bubble cycle per packet for arbitration, plus one header beat when UART_TX_ARBITER_HDR_EN is defined; data beats then pass through combinationally.
// Backpressure: out_ready_i drives the owner's in_ready_o directly. Only valid-low gaps count toward the timeout; ready-low stalls do not.
//
// Optional feature macro: UART_TX_ARBITER_HDR_EN. When it is defined, each packet is preceded by a header byte 8'hA0 | owner.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_data_i/valid/last    per-requester byte stream (requester k owns in_data_i[8k+7:8k])
//   in_ready_o              per-requester ready; only the owner's bit can be set
//   out_data_o/valid/ready  byte stream to the UART input port
//   grant_o                 one-hot current owner, 0 when idle
//   busy_o                  high while a packet is in progress
//   timeout_o               one-cycle pulse when a stalled packet is aborted
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ*8-1:0] in_data_i,
  input  logic [N_REQ-1:0]   in_valid_i,
  input  logic [N_REQ-1:0]   in_last_i,
  output logic [N_REQ-1:0]   in_ready_o,
  output logic [7:0]         out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef UART_TX_ARBITER_HDR_EN
    , ST_HDR = 2'd2
`endif
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sel_vld;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_own_vld;
  logic               w_own_last;
  logic [7:0]         w_own_dat;
  logic               w_accept;
  logic               w_done;
  logic               w_expire;

  assign w_own_vld  = in_valid_i[r_owner];
  assign w_own_last = in_last_i[r_owner];
  assign w_own_dat  = in_data_i[{r_owner, 3'b000} +: 8];
  assign w_accept   = (r_state == ST_DATA) && w_own_vld && out_ready_i;
  assign w_done     = w_accept && w_own_last;
  assign grant_o    = r_grant;

  // Round-robin pick: first valid requester strictly after the last owner.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = IDX_W'((int'(r_rr) + i) % N_REQ);
      if (!w_sel_vld && in_valid_i[w_cand]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // The counter holds the number of earlier consecutive valid-low cycles.
  // The abort therefore fires on the TIMEOUT-th such cycle itself.
  // A cycle with valid high is never an expiry, so a last beat always wins.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign w_expire = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
      assign w_expire = (r_state == ST_DATA) && !w_own_vld && (r_cnt == LP_CNT_LAST);
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_vld) begin
`ifdef UART_TX_ARBITER_HDR_EN
          w_state_nxt = ST_HDR;
`else
          w_state_nxt = ST_DATA;
`endif
        end
      end
`ifdef UART_TX_ARBITER_HDR_EN
      ST_HDR: begin
        if (out_ready_i) w_state_nxt = ST_DATA;
      end
`endif
      ST_DATA: begin
        if (w_done || w_expire) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = 8'h00;
    in_ready_o  = '0;
    timeout_o   = 1'b0;
    busy_o      = (r_state != ST_IDLE);
    case (r_state)
      ST_DATA: begin
        out_valid_o         = w_own_vld;
        out_data_o          = w_own_dat;
        in_ready_o[r_owner] = out_ready_i;
        timeout_o           = w_expire;
      end
`ifdef UART_TX_ARBITER_HDR_EN
      ST_HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = 8'hA0 | 8'(r_owner);
      end
`endif
      default: begin
      end
    endcase
  end

  // Owner, grant and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= IDX_W'(N_REQ - 1);
    end else if (r_state == ST_IDLE) begin
      if (w_sel_vld) begin
        r_owner <= w_sel_idx;
        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
      end
    end else if (w_done || w_expire) begin
      r_rr    <= r_owner;
      r_grant <= '0;
    end
  end

  // The counter is cleared outside DATA, so it always enters DATA at zero.
  // Backpressure (valid high, ready low) leaves it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((r_state != ST_DATA) || w_accept || w_expire || (TIMEOUT == 0)) begin
      r_cnt <= '0;
    end else if (!w_own_vld) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8).
// Expected values come from fixed vector tables and a packet/owner-level reference model.
// The bench follows the header-byte option when UART_TX_ARBITER_HDR_EN is defined.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
`ifdef UART_TX_ARBITER_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*8-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [7:0]     out_data;
  logic           out_valid, out_ready;
  logic [N-1:0]   grant;
  logic           busy, timeout;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester-side packet queues: {last, data}
  logic [8:0] q [N][$];
  int         stall_left [N];
  logic [N-1:0] hs_q, grant_q;
  logic         to_q, busy_q;

  // Reference model: who owns the link, who was last served, how long the owner has been silent
  int m_owner, m_last, m_quiet;
  bit m_hdr;

  typedef struct {
    string       name;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        r;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[$];

  int owners[$];
  int gaps[$];
  int gap_run, n_to, got;
  logic [N-1:0] prev_g;

  function automatic logic [18:0] pk(logic v, logic [7:0] d, logic [3:0] r, logic [3:0] g, logic b, logic t);
    return {v, d, r, g, b, t};
  endfunction

  function automatic void add(string nm, logic [3:0] v, logic [31:0] d, logic [3:0] l, logic r, logic [18:0] e);
    vec_t x;
    x.name = nm; x.v = v; x.d = d; x.l = l; x.r = r; x.exp = e;
    tbl.push_back(x);
  endfunction

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int oh2idx(logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_last = N - 1; m_quiet = 0; m_hdr = 1'b0;
  endfunction

  function automatic logic [18:0] model_exp();
    logic ev, eb, et;
    logic [7:0] ed;
    logic [3:0] er, eg;
    ev = 0; eb = 0; et = 0; ed = 8'h00; er = 4'b0; eg = 4'b0;
    if (m_owner >= 0) begin
      eg = 4'(1 << m_owner);
      eb = 1'b1;
      if (m_hdr) begin
        ev = 1'b1;
        ed = 8'hA0 + 8'(m_owner);
      end else begin
        ev = in_valid[m_owner];
        ed = in_data[8*m_owner +: 8];
        er[m_owner] = out_ready;
        et = !in_valid[m_owner] && (m_quiet + 1 == TO);
      end
    end
    return pk(ev, ed, er, eg, eb, et);
  endfunction

  function automatic void model_step();
    int c;
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_hdr = HDR_EN;
        m_quiet = 0;
      end
    end else if (m_hdr) begin
      if (out_ready) m_hdr = 1'b0;
    end else if (in_valid[m_owner]) begin
      if (out_ready) begin
        m_quiet = 0;
        if (in_last[m_owner]) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
    end else begin
      m_quiet++;
      if (m_quiet == TO) begin
        m_last = m_owner;
        m_owner = -1;
        m_quiet = 0;
      end
    end
  endfunction

  // Inputs are already applied (posedge+1). Compare at posedge+2, step the model, move to the next posedge+1.
  task automatic tick();
    logic [18:0] act, exp;
    #1;
    exp = model_exp();
    act = {out_valid, out_data, in_ready, grant, busy, timeout};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle t=%0t: got {v,d,rdy,g,busy,to}=%b expected %b", $time, act, exp);
    end
    hs_q = in_valid & in_ready;
    to_q = timeout;
    grant_q = grant;
    busy_q = busy;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_pkt(int k, int n, logic [7:0] base);
    for (int i = 0; i < n; i++) q[k].push_back({(i == n - 1), base + 8'(i)});
  endfunction

  task automatic drive_cycle(int vprob, int rprob);
    for (int k = 0; k < N; k++) begin
      in_valid[k] = (q[k].size() != 0) && (stall_left[k] == 0) && ($urandom_range(99) < vprob);
      if (q[k].size() != 0) begin
        in_data[8*k +: 8] = q[k][0][7:0];
        in_last[k] = q[k][0][8];
      end else begin
        in_data[8*k +: 8] = 8'h00;
        in_last[k] = 1'b0;
      end
    end
    out_ready = ($urandom_range(99) < rprob);
    tick();
    for (int k = 0; k < N; k++) begin
      if (hs_q[k]) void'(q[k].pop_front());
      if (stall_left[k] > 0) stall_left[k]--;
    end
  endtask

  task automatic clear_stim();
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      stall_left[k] = 0;
    end
    model_reset();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fixed vectors: a three-byte packet from requester 2 with one stall cycle, then a one-byte packet from requester 3.
    add("reset",     4'b0000, 32'h0000_0000, 4'b0000, 1'b1, pk(0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    add("t1_bubble", 4'b0100, 32'h0011_0000, 4'b0000, 1'b1, pk(0, 8'h00, 4'b0000, 4'b0000, 0, 0));
`ifdef UART_TX_ARBITER_HDR_EN
    add("t1_hdr",    4'b0100, 32'h0011_0000, 4'b0000, 1'b1, pk(1, 8'hA2, 4'b0000, 4'b0100, 1, 0));
`endif
    add("t1_b0",     4'b0100, 32'h0011_0000, 4'b0000, 1'b1, pk(1, 8'h11, 4'b0100, 4'b0100, 1, 0));
    add("t1_stall",  4'b0100, 32'h0022_0000, 4'b0000, 1'b0, pk(1, 8'h22, 4'b0000, 4'b0100, 1, 0));
    add("t1_b1",     4'b0100, 32'h0022_0000, 4'b0000, 1'b1, pk(1, 8'h22, 4'b0100, 4'b0100, 1, 0));
    add("t1_b2",     4'b0100, 32'h0033_0000, 4'b0100, 1'b1, pk(1, 8'h33, 4'b0100, 4'b0100, 1, 0));
    add("t1_idle",   4'b0000, 32'h0000_0000, 4'b0000, 1'b1, pk(0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    add("t6_bubble", 4'b1000, 32'h5500_0000, 4'b1000, 1'b1, pk(0, 8'h00, 4'b0000, 4'b0000, 0, 0));
`ifdef UART_TX_ARBITER_HDR_EN
    add("t6_hdr",    4'b1000, 32'h5500_0000, 4'b1000, 1'b1, pk(1, 8'hA3, 4'b0000, 4'b1000, 1, 0));
`endif
    add("t6_b0",     4'b1000, 32'h5500_0000, 4'b1000, 1'b1, pk(1, 8'h55, 4'b1000, 4'b1000, 1, 0));
    add("t6_idle",   4'b0000, 32'h0000_0000, 4'b0000, 1'b1, pk(0, 8'h00, 4'b0000, 4'b0000, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; out_ready = tbl[i].r;
      #1;
      n_vec++;
      if ({out_valid, out_data, in_ready, grant, busy, timeout} !== tbl[i].exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", tbl[i].name,
                 {out_valid, out_data, in_ready, grant, busy, timeout}, tbl[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // Fairness: all requesters continuously valid with two-byte packets
    do_reset();
    for (int k = 0; k < N; k++) begin
      push_pkt(k, 2, 8'(16 * k));
      push_pkt(k, 2, 8'(16 * k));
    end
    owners.delete(); gaps.delete(); gap_run = 0; prev_g = '0;
    for (int c = 0; c < 100 && owners.size() < 5; c++) begin
      drive_cycle(100, 100);
      if (grant_q != 0 && prev_g == 0) begin
        if (owners.size() != 0) gaps.push_back(gap_run);
        owners.push_back(oh2idx(grant_q));
        gap_run = 0;
      end else if (grant_q == 0) begin
        gap_run++;
      end
      prev_g = grant_q;
    end
    check("t2_npkts", owners.size(), 5);
    for (int i = 0; i < owners.size(); i++) check($sformatf("t2_owner%0d", i), owners[i], i % N);
    check("t2_ngaps", gaps.size(), 4);
    for (int i = 0; i < gaps.size(); i++) check($sformatf("t2_gap%0d", i), gaps[i], 1);

    // Long backpressure on requester 1 mid-packet never times out
    do_reset();
    push_pkt(1, 3, 8'h40);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      drive_cycle(100, 100);
      got = int'(hs_q[1]);
    end
    check("t3_first_beat", got, 1);
    n_to = 0;
    for (int c = 0; c < 2000; c++) begin
      drive_cycle(100, 0);
      n_to += int'(to_q);
    end
    check("t3_grant_held", int'(grant_q), 2);
    for (int c = 0; c < 10 && q[1].size() != 0; c++) begin
      drive_cycle(100, 100);
      n_to += int'(to_q);
    end
    check("t3_pkt_done", q[1].size(), 0);
    check("t3_no_timeout", n_to, 0);
    drive_cycle(100, 100);
    check("t3_idle_busy", int'(busy_q), 0);

    // Requester 0 goes silent mid-packet: abort on the TO-th silent cycle, then requester 1 wins
    do_reset();
    in_valid = 4'b0001; in_data = 32'h0000_00AA; in_last = 4'b0000; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      got = int'(hs_q[0]);
    end
    check("t4_first_beat", got, 1);
    in_valid = 4'b0000;
    got = 0;
    for (int c = 1; c <= TO + 4 && got == 0; c++) begin
      tick();
      if (to_q) got = c;
    end
    check("t4_timeout_cycle", got, TO);
    in_valid = 4'b0011; in_data = 32'h0000_77BB; in_last = 4'b0011;
    tick();
    tick();
    check("t4_next_grant", int'(grant_q), 2);

    // Asynchronous reset mid-packet
    do_reset();
    push_pkt(0, 1, 8'h01);
    for (int c = 0; c < 10 && q[0].size() != 0; c++) drive_cycle(100, 100);
    check("t5_pkt0_done", q[0].size(), 0);
    drive_cycle(100, 100);
    push_pkt(1, 4, 8'h60);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      drive_cycle(100, 100);
      got = int'(hs_q[1]);
    end
    check("t5_first_beat", got, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_reset", int'({out_valid, out_data, in_ready, grant, busy, timeout}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stim();
    in_valid = 4'b0011; in_data = 32'h0000_2101; in_last = 4'b0011; out_ready = 1'b1;
    tick();
    tick();
    check("t5_fresh_grant", int'(grant_q), 1);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (q[k].size() < 6 && $urandom_range(9) == 0) push_pkt(k, $urandom_range(1, 4), 8'($urandom));
        if (stall_left[k] == 0 && $urandom_range(99) < 2) stall_left[k] = $urandom_range(4, 12);
      end
      drive_cycle(75, 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
